// File: rtl/wolfram_ca_engine.sv
// Elementary (radius-1) cellular-automaton engine. It applies a run-time loadable
// 8-bit Wolfram rule to WIDTH cells and advances one generation per clock while in RUN.
module wolfram_ca_engine #(
    parameter int          WIDTH        = 16,
    parameter int          CNT_W        = 8,
    parameter logic [7:0]  DEFAULT_RULE = 8'h91
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rule_in,
    input  logic             rule_we,
    input  logic [WIDTH-1:0] seed,
    input  logic             wrap_mode,
    input  logic [CNT_W-1:0] gens,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] state_out,
    output logic [CNT_W-1:0] gen_count,
    output logic [7:0]       rule_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    fsm_e             state_q;
    logic [7:0]       rule_q;
    logic [WIDTH-1:0] row_q;
    logic [WIDTH-1:0] row_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] gens_q;
    logic             wrap_q;
    logic             busy_q;
    logic             done_q;

    // Row padded with both boundary cells: ext[j] holds cell[j-1], so ext[0] is
    // cell[-1] and ext[WIDTH+1] is cell[WIDTH].
    logic [WIDTH+1:0] ext;

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin
        ext   = {(wrap_q ? row_q[0] : 1'b0), row_q, (wrap_q ? row_q[WIDTH-1] : 1'b0)};
        row_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row_d[i] = rule_q[ext[i +: 3]];
        end
        cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values and all cells update simultaneously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rule_q  <= DEFAULT_RULE;
            row_q   <= '0;
            cnt_q   <= '0;
            gens_q  <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A rule write in the start cycle lands at the same edge, ahead of generation 1.
                    if (rule_we) begin
                        rule_q <= rule_in;
                    end
                    if (start) begin
                        row_q  <= seed;
                        cnt_q  <= '0;
                        gens_q <= gens;
                        wrap_q <= wrap_mode;
                        if (gens == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    row_q <= row_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == gens_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = row_q;
    assign gen_count = cnt_q;
    assign rule_out  = rule_q;

endmodule
